stream_upsizer: RTL and testbench

- Downstream neighbour of the 8-bit skid buffer.
- Packs the 8-bit valid/ready/last byte stream into RATIO-byte words with a per-byte keep mask, for the wide packet datapath.
- Sustains 1 byte/cycle input with no bubbles when the output is not back-pressured.
- Respects packet boundaries: in_last always closes the current word.

---
 rtl/stream_pkg.sv | 21 ++
 rtl/stream_out_slot.sv | 45 ++++
 rtl/stream_upsizer.sv | 144 ++++++++++++++
 tb/tb_stream_upsizer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// stream_pkg
//   Shared constants and helpers for the byte-stream blocks.
//   BYTE_W    : width of one stream byte
//   LEN_W     : width of the packet byte-length field
//   keep_mask : byte count (0..8) -> thermometer keep mask, low bits set
package stream_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;

  // count=3 -> 8'b0000_0111; count=8 -> 8'hFF
  function automatic logic [7:0] keep_mask(input logic [3:0] count);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(count)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_out_slot.sv
// stream_out_slot
//   Single-entry output register for a valid/ready stream. A loaded word is
//   held stable until the consumer takes it; the slot can be reloaded on the
//   same edge as a transfer, so back-to-back words flow without a bubble.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   i_load       : load i_data into the slot this edge (only when o_can_load)
//   i_data       : word to load
//   o_can_load   : slot is empty or is being emptied this cycle
//   o_data       : held word
//   o_valid      : slot holds a word
//   i_ready      : consumer accepts the word this cycle
module stream_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_can_load,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_can_load = !r_valid || i_ready;
  assign o_data     = r_data;
  assign o_valid    = r_valid;

endmodule

// File: rtl/stream_upsizer.sv
// stream_upsizer
//   Packs an 8-bit valid/ready/last byte stream into RATIO-byte words with a
//   per-byte keep mask. in_last always closes the current word. Sustains one
//   byte per cycle when the output is not back-pressured.
// Build option:
//   UPSIZE_LEN_EN : adds out_len, the total packet byte count, presented on
//                   the word that carries the packet's last byte.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   in_data/in_valid/
//   in_last/in_ready     : byte stream input
//   out_data/out_keep/
//   out_valid/out_last/
//   out_ready            : word stream output, byte k at out_data[8k+7:8k]
//   out_len              : packet length (UPSIZE_LEN_EN only)
module stream_upsizer
  import stream_pkg::*;
#(
  parameter  int RATIO = 4,
  localparam int CNT_W = $clog2(RATIO)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [BYTE_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]        out_keep,
  output logic                    out_valid,
  output logic                    out_last,
`ifdef UPSIZE_LEN_EN
  output logic [LEN_W-1:0]        out_len,
`endif
  input  logic                    out_ready
);

  localparam int WORD_W = BYTE_W * RATIO;
`ifdef UPSIZE_LEN_EN
  localparam int PAY_W = LEN_W + 1 + RATIO + WORD_W;
`else
  localparam int PAY_W = 1 + RATIO + WORD_W;
`endif

  generate
    if (RATIO != 2 && RATIO != 4 && RATIO != 8) begin : g_bad_ratio
      $error("stream_upsizer: RATIO must be 2, 4 or 8");
    end
  endgenerate

  logic [RATIO-2:0][BYTE_W-1:0] r_acc;
  logic [CNT_W-1:0]             r_cnt;

  logic              w_slot_can_load;
  logic              w_accept;
  logic              w_complete;
  logic [WORD_W-1:0] w_word;
  logic [7:0]        w_mask8;
  logic [RATIO-1:0]  w_keep;
  logic [PAY_W-1:0]  w_pay;
  logic [PAY_W-1:0]  w_slot_data;

  // Gated by reset so upstream sees no acceptance while the block is held.
  assign in_ready   = reset && w_slot_can_load;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (in_last || r_cnt == CNT_W'(RATIO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        for (int k = 0; k < RATIO - 1; k++) begin
          if (r_cnt == CNT_W'(k)) r_acc[k] <= in_data;
        end
      end
    end
  end

  // Word assembly: stored bytes below cnt, the incoming byte at cnt, zeros
  // above, so stale accumulator contents never leak into a short word.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_word
      if (gi < RATIO - 1) begin : g_acc_byte
        assign w_word[gi*BYTE_W +: BYTE_W] =
          (CNT_W'(gi) < r_cnt)  ? r_acc[gi] :
          (CNT_W'(gi) == r_cnt) ? in_data   : '0;
      end else begin : g_top_byte
        assign w_word[gi*BYTE_W +: BYTE_W] =
          (CNT_W'(gi) == r_cnt) ? in_data : '0;
      end
    end
  endgenerate

  assign w_mask8 = keep_mask(4'(r_cnt) + 4'd1);
  assign w_keep  = w_mask8[RATIO-1:0];

`ifdef UPSIZE_LEN_EN
  logic [LEN_W-1:0] r_len_cnt;
  logic [LEN_W-1:0] w_len_next;
  logic [LEN_W-1:0] w_len_word;

  assign w_len_next = (r_len_cnt == {LEN_W{1'b1}}) ? r_len_cnt : r_len_cnt + LEN_W'(1);
  assign w_len_word = in_last ? w_len_next : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_cnt <= '0;
    end else if (w_accept) begin
      r_len_cnt <= in_last ? '0 : w_len_next;
    end
  end

  assign w_pay = {w_len_word, in_last, w_keep, w_word};
`else
  assign w_pay = {in_last, w_keep, w_word};
`endif

  stream_out_slot #(
    .W (PAY_W)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_complete),
    .i_data     (w_pay),
    .o_can_load (w_slot_can_load),
    .o_data     (w_slot_data),
    .o_valid    (out_valid),
    .i_ready    (out_ready)
  );

  assign out_data = w_slot_data[WORD_W-1:0];
  assign out_keep = w_slot_data[WORD_W +: RATIO];
  assign out_last = w_slot_data[WORD_W + RATIO];
`ifdef UPSIZE_LEN_EN
  assign out_len  = w_slot_data[WORD_W + RATIO + 1 +: LEN_W];
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
module tb_stream_upsizer;

  localparam int RATIO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_last;
`ifdef UPSIZE_LEN_EN
  logic [15:0] out_len;
`endif

  stream_upsizer #(.RATIO(RATIO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_last  (out_last),
`ifdef UPSIZE_LEN_EN
    .out_len   (out_len),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fails  = 0;
  int n_words  = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] len;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] m_acc[$];
  int         m_len = 0;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        l;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last;
    logic [15:0] e_len;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference packer: bytes accumulate until RATIO collected or last seen.
  task automatic model_push(input logic [7:0] d, input logic l);
    word_t w;
    m_acc.push_back(d);
    m_len++;
    if (l || m_acc.size() == RATIO) begin
      w.data = '0;
      for (int i = 0; i < m_acc.size(); i++) w.data[i*8 +: 8] = m_acc[i];
      w.keep = 4'((1 << m_acc.size()) - 1);
      w.last = l;
      w.len  = l ? ((m_len > 65535) ? 16'hFFFF : 16'(m_len)) : 16'h0;
      if (l) m_len = 0;
      m_acc.delete();
      exp_q.push_back(w);
    end
  endtask

  task automatic check_pop();
    word_t w;
    n_words++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL unexpected_word: got data=%08h keep=%h last=%0b expected no word", out_data, out_keep, out_last);
    end else begin
      w = exp_q.pop_front();
      $display("word %0d data=%08h keep=%h last=%0b", n_words, out_data, out_keep, out_last);
      chk("word_data", 64'(out_data), 64'(w.data));
      chk("word_keep", 64'(out_keep), 64'(w.keep));
      chk("word_last", 64'(out_last), 64'(w.last));
`ifdef UPSIZE_LEN_EN
      chk("word_len", 64'(out_len), 64'(w.len));
`endif
    end
  endtask

  // One clock: drive at negedge, observe 1 time unit later. A transfer or
  // acceptance seen here takes effect at the following rising edge.
  task automatic cycle(input logic [7:0] d, input logic v, input logic l,
                       input logic ordy, output logic acc);
    @(negedge clk);
    in_data   = d;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (out_valid && out_ready) check_pop();
    if (acc) model_push(d, l);
  endtask

  task automatic drain();
    logic acc;
    repeat (12) cycle(8'h00, 1'b0, 1'b0, 1'b1, acc);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_bounded(input logic [7:0] d, input logic l, input string name);
    logic acc;
    int   budget;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 50) begin
      cycle(d, 1'b1, l, 1'b1, acc);
      budget++;
    end
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: byte %02h got not accepted expected accepted", name, d);
    end
  endtask

  initial begin
    logic        acc;
    logic        ordy;
    int          budget;
    int          words_before;
    logic [31:0] held;

    //           d      v     l     ordy  ir    ov    data          keep  last  len
    vecs[0]  = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[1]  = '{8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[2]  = '{8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[3]  = '{8'h14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[4]  = '{8'h15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h14131211, 4'hF, 1'b0, 16'd0};
    vecs[5]  = '{8'h16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[6]  = '{8'h17, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[7]  = '{8'h18, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[8]  = '{8'hA1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h18171615, 4'hF, 1'b1, 16'd8};
    vecs[9]  = '{8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[10] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[11] = '{8'h5C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00A3A2A1, 4'h7, 1'b1, 16'd3};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000005C, 4'h1, 1'b1, 16'd1};
    vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};

    // Reset state
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_keep",  64'(out_keep),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table: continuous packing, short packet, single-byte packet
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_data   = vecs[i].d;
      in_valid  = vecs[i].v;
      in_last   = vecs[i].l;
      out_ready = vecs[i].ordy;
      #1;
      $display("vec %0d in=%02h v=%0b l=%0b ir=%0b ov=%0b data=%08h keep=%h last=%0b",
               i, vecs[i].d, vecs[i].v, vecs[i].l, in_ready, out_valid, out_data, out_keep, out_last);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].e_data));
        chk($sformatf("vec%0d_keep", i), 64'(out_keep), 64'(vecs[i].e_keep));
        chk($sformatf("vec%0d_last", i), 64'(out_last), 64'(vecs[i].e_last));
`ifdef UPSIZE_LEN_EN
        chk($sformatf("vec%0d_len", i), 64'(out_len), 64'(vecs[i].e_len));
`endif
      end
    end

    // Stall: output held for 10 cycles, input blocked, then nothing lost
    for (int b = 0; b < 4; b++) begin
      cycle(8'h21 + 8'(b), 1'b1, 1'b0, 1'b1, acc);
      chk("stall_fill_accept", 64'(acc), 64'd1);
    end
    held = (exp_q.size() > 0) ? exp_q[0].data : 32'hDEADBEEF;
    chk("stall_expected_word", 64'(held), 64'h24232221);
    for (int c = 0; c < 10; c++) begin
      cycle(8'h25, 1'b1, 1'b0, 1'b0, acc);
      chk("stall_in_ready",  64'(in_ready),  64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_data",  64'(out_data),  64'(held));
      chk("stall_out_keep",  64'(out_keep),  64'hF);
    end
    for (int b = 0; b < 7; b++) begin
      send_bounded(8'h25 + 8'(b), (b == 6), "stall_resume");
    end
    drain();

    // Reset mid-word: partial bytes must vanish
    cycle(8'h31, 1'b1, 1'b0, 1'b1, acc);
    cycle(8'h32, 1'b1, 1'b0, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    m_acc.delete();
    m_len = 0;
    #1;
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    words_before = n_words;
    for (int b = 0; b < 4; b++) send_bounded(8'h01 + 8'(b), 1'b0, "postrst_send");
    drain();
    chk("postrst_word_count", 64'(n_words - words_before), 64'd1);

    // Random: out_ready toggles every cycle, random in_valid, 1000 packets
    ordy = 1'b0;
    budget = 0;
    for (int p = 0; p < 1000 && budget < 60000; p++) begin
      int plen;
      plen = $urandom_range(1, 9);
      for (int b = 0; b < plen && budget < 60000; b++) begin
        logic [7:0] d;
        d = 8'($urandom);
        acc = 1'b0;
        while (!acc && budget < 60000) begin
          ordy = ~ordy;
          cycle(d, ($urandom_range(0, 3) != 0), (b == plen - 1), ordy, acc);
          budget++;
        end
      end
    end
    if (budget >= 60000) begin
      n_checks++;
      n_fails++;
      $display("FAIL random_budget: got %0d cycles expected under 60000", budget);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
